// File: rtl/adc_stream_pkg.sv
// Shared constants, FSM states and helpers for the ADC frame streamer.
package adc_stream_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam logic [BYTE_W-1:0] DEFAULT_HEADER = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_LOAD = 3'd2,
        S_SEND = 3'd3,
        S_WAIT = 3'd4
    } state_e;

    // Bytes needed to carry one sample of the given bit width.
    function automatic int unsigned bytes_per_sample(input int unsigned width);
        return (width + BYTE_W - 1) / BYTE_W;
    endfunction

endpackage

// File: rtl/frame_bank_ram.sv
// Ping-pong frame storage: one write port, one registered read port (BRAM style).
module frame_bank_ram #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    localparam int unsigned WORDS = 1 << ADDR_W;

    logic [WIDTH-1:0] mem [WORDS];
    logic [WIDTH-1:0] rd_data_q;

    // No reset on storage or read register so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/adc_frame_streamer.sv
// Buffers ADC samples into two frame banks and streams full frames as bytes
// (optional header, then each sample MSB byte first) into an SPI master.
module adc_frame_streamer
    import adc_stream_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEPTH     = 8,
    parameter bit          HEADER_EN = 1'b1,
    parameter logic [7:0]  HEADER    = DEFAULT_HEADER
) (
    input  logic             i_Clk,
    input  logic             i_Rst_L,
    input  logic             i_Enable,
    input  logic [WIDTH-1:0] i_Sample,
    input  logic             i_Sample_DV,
    output logic [7:0]       o_TX_Byte,
    output logic             o_TX_DV,
    input  logic             i_TX_Ready,
    output logic             o_Busy,
    output logic             o_Frame_Done,
    output logic             o_Overflow,
    output logic [7:0]       o_Drop_Count
);

    localparam int unsigned BPS    = bytes_per_sample(WIDTH);
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned ADDR_W = PTR_W + 1;
    localparam int unsigned WORD_W = BPS * BYTE_W;
    localparam int unsigned BIDX_W = $clog2(BPS + 1);

    state_e             state_q, state_d;
    logic               wr_bank_q, wr_bank_d;
    logic               rd_bank_q, rd_bank_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [1:0]         full_q, full_d;
    logic [BIDX_W-1:0]  byte_idx_q, byte_idx_d;
    logic               hdr_sent_q, hdr_sent_d;
    logic               busy_q, busy_d;
    logic               frame_done_q, frame_done_d;
    logic               overflow_q, overflow_d;
    logic [7:0]         drop_cnt_q, drop_cnt_d;

    logic               wr_en_c;
    logic               rd_en_c;
    logic               tx_dv_c;
    logic [7:0]         tx_byte_c;
    logic [WIDTH-1:0]   rd_data;
    logic [WORD_W-1:0]  word_c;

    frame_bank_ram #(
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (i_Clk),
        .wr_en   (wr_en_c),
        .wr_addr ({wr_bank_q, wr_ptr_q}),
        .wr_data (i_Sample),
        .rd_en   (rd_en_c),
        .rd_addr ({rd_bank_q, rd_ptr_q}),
        .rd_data (rd_data)
    );

    assign word_c = WORD_W'(rd_data);

    // Read FSM plus write-side bookkeeping.
    always_comb begin
        state_d      = state_q;
        wr_bank_d    = wr_bank_q;
        rd_bank_d    = rd_bank_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        full_d       = full_q;
        byte_idx_d   = byte_idx_q;
        hdr_sent_d   = hdr_sent_q;
        frame_done_d = 1'b0;
        overflow_d   = overflow_q;
        drop_cnt_d   = drop_cnt_q;
        wr_en_c      = 1'b0;
        rd_en_c      = 1'b0;
        tx_dv_c      = 1'b0;
        tx_byte_c    = 8'h00;

        case (state_q)
            S_IDLE: begin
                if (full_q[rd_bank_q]) begin
                    state_d = HEADER_EN ? S_HDR : S_LOAD;
                end
            end
            S_HDR: begin
                tx_byte_c = HEADER;
                if (i_TX_Ready) begin
                    tx_dv_c    = 1'b1;
                    hdr_sent_d = 1'b1;
                    state_d    = S_WAIT;
                end
            end
            S_LOAD: begin
                rd_en_c    = 1'b1;
                byte_idx_d = BIDX_W'(BPS - 1);
                state_d    = S_SEND;
            end
            S_SEND: begin
                tx_byte_c = BYTE_W'(word_c >> {byte_idx_q, 3'b000});
                if (i_TX_Ready) begin
                    tx_dv_c = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // Dead cycle lets the SPI master drop ready before the next byte.
                if (hdr_sent_q) begin
                    hdr_sent_d = 1'b0;
                    state_d    = S_LOAD;
                end else if (byte_idx_q != '0) begin
                    byte_idx_d = byte_idx_q - BIDX_W'(1);
                    state_d    = S_SEND;
                end else if (rd_ptr_q != PTR_W'(DEPTH - 1)) begin
                    rd_ptr_d = rd_ptr_q + PTR_W'(1);
                    state_d  = S_LOAD;
                end else begin
                    frame_done_d      = 1'b1;
                    full_d[rd_bank_q] = 1'b0;
                    rd_bank_d         = ~rd_bank_q;
                    rd_ptr_d          = '0;
                    state_d           = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Write side uses the registered full flag, so a bank freed this cycle still drops.
        if (!i_Enable) begin
            wr_ptr_d = '0;
        end else if (i_Sample_DV) begin
            if (full_q[wr_bank_q]) begin
                overflow_d = 1'b1;
                if (drop_cnt_q != 8'hFF) begin
                    drop_cnt_d = drop_cnt_q + 8'd1;
                end
            end else begin
                wr_en_c = 1'b1;
                if (wr_ptr_q == PTR_W'(DEPTH - 1)) begin
                    full_d[wr_bank_q] = 1'b1;
                    wr_bank_d         = ~wr_bank_q;
                    wr_ptr_d          = '0;
                end else begin
                    wr_ptr_d = wr_ptr_q + PTR_W'(1);
                end
            end
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q      <= S_IDLE;
            wr_bank_q    <= 1'b0;
            rd_bank_q    <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            full_q       <= 2'b00;
            byte_idx_q   <= '0;
            hdr_sent_q   <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
            drop_cnt_q   <= 8'h00;
        end else begin
            state_q      <= state_d;
            wr_bank_q    <= wr_bank_d;
            rd_bank_q    <= rd_bank_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            full_q       <= full_d;
            byte_idx_q   <= byte_idx_d;
            hdr_sent_q   <= hdr_sent_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    // Byte/valid follow the FSM state and ready directly to meet the handshake timing.
    assign o_TX_DV      = tx_dv_c;
    assign o_TX_Byte    = tx_byte_c;
    assign o_Busy       = busy_q;
    assign o_Frame_Done = frame_done_q;
    assign o_Overflow   = overflow_q;
    assign o_Drop_Count = drop_cnt_q;

endmodule

// File: tb/tb_adc_frame_streamer.sv
// Self-checking bench: frame-level reference model for an 8x8 instance plus a
// table of split-sample vectors for a 12-bit, 2-deep instance.
module tb_adc_frame_streamer;

    localparam int DEPTH       = 8;
    localparam int FRAME_BYTES = DEPTH + 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en, sdv, rdy;
    logic [7:0] smp;
    logic [7:0] tx_byte, dcnt;
    logic       tx_dv, busy, fdone, ovf;

    logic        sdv12;
    logic [11:0] s12;
    logic [7:0]  byte12, dcnt12;
    logic        dv12, busy12, fd12, ovf12;

    always #5 clk = ~clk;

    adc_frame_streamer #(.WIDTH(8), .DEPTH(8), .HEADER_EN(1'b1), .HEADER(8'hA5)) dut (
        .i_Clk(clk), .i_Rst_L(rst_n), .i_Enable(en), .i_Sample(smp), .i_Sample_DV(sdv),
        .o_TX_Byte(tx_byte), .o_TX_DV(tx_dv), .i_TX_Ready(rdy), .o_Busy(busy),
        .o_Frame_Done(fdone), .o_Overflow(ovf), .o_Drop_Count(dcnt)
    );

    adc_frame_streamer #(.WIDTH(12), .DEPTH(2), .HEADER_EN(1'b1), .HEADER(8'hA5)) dut12 (
        .i_Clk(clk), .i_Rst_L(rst_n), .i_Enable(1'b1), .i_Sample(s12), .i_Sample_DV(sdv12),
        .o_TX_Byte(byte12), .o_TX_DV(dv12), .i_TX_Ready(1'b1), .o_Busy(busy12),
        .o_Frame_Done(fd12), .o_Overflow(ovf12), .o_Drop_Count(dcnt12)
    );

    int n_chk = 0;
    int n_fail = 0;

    // Reference model state
    logic [7:0] exp_q[$];
    logic [7:0] partial[$];
    logic [7:0] cap12[$];
    int pending, drops, bytes_in_frame, n_dv, n_fd, cyc, last_dv_cyc;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
        end
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        partial.delete();
        pending        = 0;
        drops          = 0;
        bytes_in_frame = 0;
        last_dv_cyc    = -1;
    endfunction

    // Frame-level model: a frame occupies a bank until its Frame_Done; with two banks
    // occupied every enabled sample is dropped.
    always @(negedge clk) begin
        if (rst_n) begin
            cyc++;
            if (fdone) begin
                check("frame_done_has_frame", 64'(pending != 0), 64'd1);
                check("frame_len", 64'(bytes_in_frame), 64'(FRAME_BYTES));
                bytes_in_frame = 0;
                if (pending > 0) pending--;
                n_fd++;
            end
            if (tx_dv) begin
                if (last_dv_cyc >= 0) check("dv_spacing", 64'((cyc - last_dv_cyc) >= 2), 64'd1);
                check("dv_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) check("tx_byte", 64'(tx_byte), 64'(exp_q.pop_front()));
                bytes_in_frame++;
                last_dv_cyc = cyc;
                n_dv++;
            end
            if (!en) begin
                partial.delete();
            end else if (sdv) begin
                if (pending >= 2) begin
                    if (drops < 255) drops++;
                end else begin
                    partial.push_back(smp);
                    if (partial.size() == DEPTH) begin
                        exp_q.push_back(8'hA5);
                        foreach (partial[i]) exp_q.push_back(partial[i]);
                        partial.delete();
                        pending++;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && dv12) cap12.push_back(byte12);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_sample(input logic [7:0] v);
        smp = v;
        sdv = 1'b1;
        tick();
        sdv = 1'b0;
    endtask

    task automatic send12(input logic [11:0] v);
        s12   = v;
        sdv12 = 1'b1;
        tick();
        sdv12 = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sdv   = 1'b0;
        sdv12 = 1'b0;
        en    = 1'b1;
        rdy   = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_fd(input int target, input int budget, input string name);
        int k = 0;
        while (n_fd < target && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        check(name, 64'(n_fd >= target), 64'd1);
    endtask

    task automatic wait_dv(input int target, input int budget, input string name);
        int k = 0;
        while (n_dv < target && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        check(name, 64'(n_dv >= target), 64'd1);
    endtask

    typedef struct {
        logic [11:0] s0;
        logic [11:0] s1;
        logic [39:0] bytes;
    } split_vec_t;

    split_vec_t vecs [4];

    initial begin
        int base_dv, base_fd, stall_dv, stall_bad, k;
        logic [5:0] dv_pat, busy_pat;
        logic [39:0] got;

        vecs[0] = '{12'hABC, 12'h123, 40'hA5_0A_BC_01_23};
        vecs[1] = '{12'hFFF, 12'h000, 40'hA5_0F_FF_00_00};
        vecs[2] = '{12'h800, 12'h07F, 40'hA5_08_00_00_7F};
        vecs[3] = '{12'h5A5, 12'hF0F, 40'hA5_05_A5_0F_0F};

        n_dv = 0; n_fd = 0; cyc = 0;
        smp = 8'h00; s12 = 12'h000;
        rst_n = 1'b0; en = 1'b1; sdv = 1'b0; sdv12 = 1'b0; rdy = 1'b1;
        model_reset();
        #2;
        check("rst_tx_dv", 64'(tx_dv), 64'd0);
        check("rst_tx_byte", 64'(tx_byte), 64'h00);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_frame_done", 64'(fdone), 64'd0);
        check("rst_overflow", 64'(ovf), 64'd0);
        check("rst_drop_count", 64'(dcnt), 64'd0);
        do_reset();
        tick();

        // Basic frame with latency and busy profile after the last sample
        base_dv = n_dv;
        base_fd = n_fd;
        for (int i = 1; i <= 8; i++) send_sample(8'(i));
        dv_pat = '0;
        busy_pat = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            dv_pat   = {dv_pat[4:0], tx_dv};
            busy_pat = {busy_pat[4:0], busy};
        end
        check("latency_dv_pattern", 64'(dv_pat), 64'(6'b010010));
        check("latency_busy_pattern", 64'(busy_pat), 64'(6'b011111));
        wait_fd(base_fd + 1, 200, "basic_frame_done");
        check("basic_busy_after", 64'(busy), 64'd0);
        check("basic_dv_count", 64'(n_dv - base_dv), 64'd9);

        // Split-sample table on the 12-bit, 2-deep instance
        for (int v = 0; v < 4; v++) begin
            cap12.delete();
            tick();
            send12(vecs[v].s0);
            send12(vecs[v].s1);
            k = 0;
            while (cap12.size() < 5 && k < 100) begin
                @(negedge clk);
                #1;
                k++;
            end
            check("split_byte_count", 64'(cap12.size()), 64'd5);
            if (cap12.size() >= 5) begin
                got = {cap12[0], cap12[1], cap12[2], cap12[3], cap12[4]};
                check("split_bytes", 64'(got), 64'(vecs[v].bytes));
            end
        end

        // Ready stall after the header
        do_reset();
        tick();
        base_dv = n_dv;
        base_fd = n_fd;
        for (int i = 1; i <= 8; i++) send_sample(8'(i));
        wait_dv(base_dv + 1, 50, "stall_header_seen");
        tick();
        rdy = 1'b0;
        stall_dv = 0;
        stall_bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            #1;
            if (tx_dv) stall_dv++;
            if (i >= 4 && tx_byte != 8'h01) stall_bad++;
        end
        check("stall_no_dv", 64'(stall_dv), 64'd0);
        check("stall_byte_held", 64'(stall_bad), 64'd0);
        tick();
        rdy = 1'b1;
        repeat (2) begin
            @(negedge clk);
            #1;
        end
        check("stall_release_one_dv", 64'(n_dv - base_dv), 64'd2);
        wait_fd(base_fd + 1, 200, "stall_frame_done");

        // Overflow with both banks held, then drop-count saturation
        do_reset();
        rdy = 1'b0;
        tick();
        base_fd = n_fd;
        for (int i = 0; i < 20; i++) send_sample(8'($urandom));
        tick();
        check("ovf_flag", 64'(ovf), 64'd1);
        check("ovf_drop_count_4", 64'(dcnt), 64'd4);
        check("ovf_drop_model", 64'(dcnt), 64'(drops));
        for (int i = 0; i < 260; i++) send_sample(8'($urandom));
        tick();
        check("ovf_drop_saturate", 64'(dcnt), 64'd255);
        rdy = 1'b1;
        wait_fd(base_fd + 2, 400, "ovf_two_frames");
        check("ovf_queue_drained", 64'(exp_q.size()), 64'd0);

        // Enable low discards the partial frame without counting drops
        do_reset();
        tick();
        base_fd = n_fd;
        for (int i = 0; i < 5; i++) send_sample(8'(8'h10 + i));
        en = 1'b0;
        for (int i = 0; i < 3; i++) send_sample(8'(8'h20 + i));
        en = 1'b1;
        for (int i = 0; i < 8; i++) send_sample(8'(8'h30 + i));
        wait_fd(base_fd + 1, 200, "enable_frame_done");
        repeat (30) tick();
        check("enable_one_frame", 64'(n_fd - base_fd), 64'd1);
        check("enable_no_drops", 64'(dcnt), 64'd0);

        // Async reset while a byte is being offered
        do_reset();
        rdy = 1'b0;
        tick();
        for (int i = 0; i < 17; i++) send_sample(8'($urandom));
        rdy = 1'b1;
        k = 0;
        while (!tx_dv && k < 50) begin
            @(negedge clk);
            #1;
            k++;
        end
        check("areset_dv_seen", 64'(tx_dv), 64'd1);
        check("areset_pre_drops", 64'(dcnt), 64'd1);
        rst_n = 1'b0;
        #1;
        check("areset_tx_dv", 64'(tx_dv), 64'd0);
        check("areset_busy", 64'(busy), 64'd0);
        check("areset_overflow", 64'(ovf), 64'd0);
        check("areset_drop_count", 64'(dcnt), 64'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        base_dv = n_dv;
        base_fd = n_fd;
        repeat (40) tick();
        check("areset_no_tx", 64'(n_dv - base_dv), 64'd0);
        check("areset_idle", 64'(busy), 64'd0);
        for (int i = 0; i < 8; i++) send_sample(8'(8'hC0 + i));
        wait_fd(base_fd + 1, 200, "areset_new_frame");

        // Randomised traffic against the model
        do_reset();
        tick();
        for (int i = 0; i < 1500; i++) begin
            en  = ($urandom_range(0, 49) != 0);
            rdy = ($urandom_range(0, 3) != 0);
            sdv = ($urandom_range(0, 2) == 0);
            smp = 8'($urandom);
            tick();
        end
        sdv = 1'b0;
        en  = 1'b1;
        rdy = 1'b1;
        k = 0;
        while (pending != 0 && k < 600) begin
            @(negedge clk);
            #1;
            k++;
        end
        check("rand_drained", 64'(pending), 64'd0);
        check("rand_queue_empty", 64'(exp_q.size()), 64'd0);
        check("rand_drop_count", 64'(dcnt), 64'(drops));
        check("rand_overflow", 64'(ovf), 64'(drops != 0));
        check("split_inst_idle", 64'({busy12, fd12, ovf12}), 64'd0);
        check("split_inst_drops", 64'(dcnt12), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
